// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [63:0] PC_INCR  = 64'd4;

  // A target is misaligned when it is not on a 4-byte instruction boundary.
  function automatic logic is_misaligned(input logic [63:0] target);
    return target[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: pc, instruction and valid, with load, hold and flush.
module if_id_register
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [63:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [63:0] pc,
  output logic [31:0] inst,
  output logic        valid
);

  // Flush outranks load; with neither asserted the contents hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= 64'h0;
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (flush) begin
      pc    <= pc_in;
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      inst  <= inst_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, fills IF/ID.
// Optional misaligned-branch trap is compiled in with MISALIGN_CHECK_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        misalign
);

  fetch_state_t state;
  logic [63:0]  pc;
  logic         bad_target;
  logic         ifid_load;
  logic         ifid_flush;

`ifdef MISALIGN_CHECK_EN
  logic misalign_q;
  assign bad_target = is_misaligned(branch_target);
  assign misalign   = misalign_q;
`else
  assign bad_target = 1'b0;
  assign misalign   = 1'b0;
`endif

  assign Inst_Address = pc;

  // A redirect (good or trapping) always flushes the wrong-path fetch.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (state == RUN) begin
      if (branch_taken) begin
        ifid_flush = 1'b1;
      end else if (!stall) begin
        ifid_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_count <= 32'd0;
`ifdef MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (branch_taken) begin
            if (bad_target) begin
              state <= TRAP;
`ifdef MISALIGN_CHECK_EN
              misalign_q <= 1'b1;
`endif
            end else begin
              pc <= branch_target;
            end
          end else if (!stall) begin
            pc          <= pc + PC_INCR;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        TRAP: state <= TRAP;
        default: state <= BOOT;
      endcase
    end
  end

  if_id_register u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .pc_in   (pc),
    .inst_in (Instruction),
    .pc      (if_id_pc),
    .inst    (if_id_inst),
    .valid   (if_id_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table, corner sequences, random run.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] inst_address;
  logic [31:0] instruction;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .Inst_Address  (inst_address),
    .Instruction   (instruction),
    .if_id_pc      (if_id_pc),
    .if_id_inst    (if_id_inst),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  always_comb instruction = mem_word(inst_address);

  // Reference model: the fetch rules stated directly on plain variables.
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_inst, m_cnt;
  logic        m_valid, m_mis, m_first, m_trap;

  task automatic model_reset();
    m_pc = 64'h0; m_ifpc = 64'h0; m_inst = NOP; m_valid = 1'b0;
    m_cnt = 32'd0; m_mis = 1'b0; m_first = 1'b1; m_trap = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic bt, input logic [63:0] tgt);
    logic trap_now;
    trap_now = 1'b0;
`ifdef MISALIGN_CHECK_EN
    trap_now = (tgt % 64'd4) != 64'd0;
`endif
    if (m_first) begin
      m_first = 1'b0;
    end else if (m_trap) begin
      // frozen until reset
    end else if (bt) begin
      m_ifpc = m_pc; m_inst = NOP; m_valid = 1'b0;
      if (trap_now) begin
        m_mis = 1'b1; m_trap = 1'b1;
      end else begin
        m_pc = tgt;
      end
    end else if (!st) begin
      m_ifpc = m_pc; m_inst = mem_word(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 64'd4; m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " addr"},  inst_address, m_pc);
    chk({tag, " ifpc"},  if_id_pc, m_ifpc);
    chk({tag, " inst"},  {32'h0, if_id_inst}, {32'h0, m_inst});
    chk({tag, " valid"}, {63'h0, if_id_valid}, {63'h0, m_valid});
    chk({tag, " count"}, {32'h0, fetch_count}, {32'h0, m_cnt});
    chk({tag, " mis"},   {63'h0, misalign}, {63'h0, m_mis});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " addr"},  inst_address, 64'h0);
    chk({tag, " ifpc"},  if_id_pc, 64'h0);
    chk({tag, " inst"},  {32'h0, if_id_inst}, {32'h0, NOP});
    chk({tag, " valid"}, {63'h0, if_id_valid}, 64'h0);
    chk({tag, " count"}, {32'h0, fetch_count}, 64'h0);
    chk({tag, " mis"},   {63'h0, misalign}, 64'h0);
  endtask

  // Called at a negedge; applies inputs for one rising edge, returns at next negedge.
  task automatic cycle(input logic st, input logic bt, input logic [63:0] tgt);
    stall = st; branch_taken = bt; branch_target = tgt;
    @(posedge clk);
    model_edge(st, bt, tgt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    @(negedge clk);
    check_reset_values("rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        st;
    logic        bt;
    logic [63:0] tgt;
    logic [63:0] addr;
    logic [63:0] ifpc;
    logic        valid;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [31:0] exp_inst;
    logic [63:0] tgt;
    logic        st, bt;

    tbl[0]  = '{1'b0, 1'b0, 64'h0,  64'h00, 64'h00, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b0, 64'h0,  64'h04, 64'h00, 1'b1, 32'd1};
    tbl[2]  = '{1'b0, 1'b0, 64'h0,  64'h08, 64'h04, 1'b1, 32'd2};
    tbl[3]  = '{1'b0, 1'b0, 64'h0,  64'h0C, 64'h08, 1'b1, 32'd3};
    tbl[4]  = '{1'b0, 1'b0, 64'h0,  64'h10, 64'h0C, 1'b1, 32'd4};
    tbl[5]  = '{1'b1, 1'b0, 64'h0,  64'h10, 64'h0C, 1'b1, 32'd4};
    tbl[6]  = '{1'b1, 1'b0, 64'h0,  64'h10, 64'h0C, 1'b1, 32'd4};
    tbl[7]  = '{1'b1, 1'b0, 64'h0,  64'h10, 64'h0C, 1'b1, 32'd4};
    tbl[8]  = '{1'b0, 1'b0, 64'h0,  64'h14, 64'h10, 1'b1, 32'd5};
    tbl[9]  = '{1'b0, 1'b0, 64'h0,  64'h18, 64'h14, 1'b1, 32'd6};
    tbl[10] = '{1'b0, 1'b1, 64'h4C, 64'h4C, 64'h18, 1'b0, 32'd6};
    tbl[11] = '{1'b0, 1'b0, 64'h0,  64'h50, 64'h4C, 1'b1, 32'd7};
    tbl[12] = '{1'b1, 1'b1, 64'h04, 64'h04, 64'h50, 1'b0, 32'd7};
    tbl[13] = '{1'b0, 1'b0, 64'h0,  64'h08, 64'h04, 1'b1, 32'd8};
    tbl[14] = '{1'b0, 1'b1, 64'h30, 64'h30, 64'h08, 1'b0, 32'd8};
    tbl[15] = '{1'b0, 1'b1, 64'h4C, 64'h4C, 64'h30, 1'b0, 32'd8};
    tbl[16] = '{1'b0, 1'b0, 64'h0,  64'h50, 64'h4C, 1'b1, 32'd9};

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    do_reset();

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].st, tbl[i].bt, tbl[i].tgt);
      exp_inst = tbl[i].valid ? mem_word(tbl[i].ifpc) : NOP;
      chk($sformatf("tbl%0d addr", i),  inst_address, tbl[i].addr);
      chk($sformatf("tbl%0d ifpc", i),  if_id_pc, tbl[i].ifpc);
      chk($sformatf("tbl%0d inst", i),  {32'h0, if_id_inst}, {32'h0, exp_inst});
      chk($sformatf("tbl%0d valid", i), {63'h0, if_id_valid}, {63'h0, tbl[i].valid});
      chk($sformatf("tbl%0d count", i), {32'h0, fetch_count}, {32'h0, tbl[i].cnt});
    end

    // PC wraps modulo 2^64
    do_reset();
    cycle(1'b0, 1'b0, 64'h0);
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    check_model("wrap_br");
    cycle(1'b0, 1'b0, 64'h0);
    chk("wrap addr", inst_address, 64'h0);
    chk("wrap ifpc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_model("wrap_seq");

    // Misaligned target: trap with checking compiled in, plain fetch otherwise
    do_reset();
    cycle(1'b0, 1'b0, 64'h0);
    cycle(1'b0, 1'b0, 64'h0);
    cycle(1'b0, 1'b1, 64'h22);
    check_model("mis_br");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 64'h0);
      check_model("mis_after");
    end
    cycle(1'b0, 1'b1, 64'h40);
    check_model("mis_br2");
    do_reset();
    check_model("mis_clr");

    // Asynchronous reset mid-stream at PC=0x40
    cycle(1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 64'h0);
    chk("pre_rst addr", inst_address, 64'h40);
    #2 reset = 1'b1;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 3) == 0);
      bt = ($urandom_range(0, 6) == 0);
      tgt = {52'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 19) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) tgt[63:32] = 32'hFFFF_FFFF;
      cycle(st, bt, tgt);
      check_model($sformatf("rnd%0d", i));
      if (m_trap && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory's byte address. It captures the returned 32-bit instruction, together with its PC, into an IF/ID pipeline register for the decoder. It handles sequential fetch, stall, and taken-branch redirect with flush.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush and reset.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents this cycle.
- branch_taken  input  1  redirect request from execute stage.
- branch_target  input  64  byte address to redirect to.
- Inst_Address  output  64  byte address to instruction memory; equals PC register.
- Instruction  input  32  instruction returned combinationally by instruction memory for Inst_Address.
- if_id_pc  output  64  PC of the captured instruction.
- if_id_inst  output  32  captured instruction.
- if_id_valid  output  1  captured instruction is real, not a bubble.
- fetch_count  output  32  number of valid instructions delivered into IF/ID.
- misalign  output  1  sticky misaligned-target flag; tied 0 when checking is compiled out.

## Operation
- Reset values: PC=RESET_PC, if_id_pc=0, if_id_inst=NOP_INST, if_id_valid=0, fetch_count=0, misalign=0, state=BOOT.
- States: BOOT, RUN, TRAP.
- BOOT lasts exactly one cycle after reset deasserts. It always moves to RUN. PC is held and IF/ID stays a bubble, so memory output settles before first capture.
- In RUN, the highest-priority condition applies:
  - branch_taken: PC <= branch_target, IF/ID <= {PC, NOP_INST, valid=0}. This flushes the wrong-path fetch and overrides stall.
  - stall: PC and all IF/ID outputs hold; fetch_count holds.
  - Otherwise: IF/ID <= {PC, Instruction, valid=1}; PC <= PC+4; fetch_count += 1.
- TRAP: PC and IF/ID frozen with if_id_valid=0. Only reset exits TRAP.
- Arithmetic: PC+4 is modulo 2^64 (wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0). fetch_count wraps from 2^32-1 to 0.
- branch_target is not re-aligned. The low bits pass through unmodified unless checking is enabled.
- Reset asserted mid-operation forces all reset values immediately, regardless of state.

## Timing
- Inst_Address changes on the same edge PC updates. No combinational path exists from any input to Inst_Address.
- Instruction-to-IF/ID latency is one cycle. A fetch at PC p in cycle n appears on if_id_* after edge n+1.
- Branch redirect: branch_taken sampled at edge k puts branch_target on Inst_Address after k. That target's instruction reaches IF/ID after edge k+1, giving exactly one bubble.
- A stall lasting N cycles holds IF/ID for N cycles. Sequential fetch resumes on the first edge with stall=0.

## Configuration
- MISALIGN_CHECK_EN defined: when branch_taken is asserted with branch_target[1:0]!=0 in RUN, the redirect is not applied. Instead misalign <= 1, IF/ID is flushed, and the state moves to TRAP.
- MISALIGN_CHECK_EN undefined: no check is made, the TRAP state is unreachable, misalign is constant 0, and misaligned targets are fetched as given.

## Structure
- Shared package fetch_pkg holds the state enum (BOOT, RUN, TRAP), the NOP_INST constant, and the PC increment constant 4.
- One sub-module: if_id_register, which holds the IF/ID pc, inst, and valid registers with load, hold, and flush controls. The PC, FSM, and counter stay in the top.

## Test plan
- Reset then run with no stall/branch, RESET_PC=0: Inst_Address is 0 in BOOT, then 0,4,8,... One cycle after BOOT, if_id_pc=0 with if_id_inst=mem[0..3] and valid=1. After 5 captures, fetch_count=5.
- branch_taken=1, branch_target=0x4C while PC=0x30: the next Inst_Address is 0x4C, the next IF/ID is NOP_INST with valid=0, and the following IF/ID has pc=0x4C with valid=1.
- stall held for 3 cycles at PC=0x10: Inst_Address stays at 0x10, IF/ID is unchanged, and fetch_count is unchanged. Fetch resumes at 0x10 after stall drops.
- stall=1 and branch_taken=1 together, target 0x04: the redirect wins, Inst_Address becomes 0x04, and IF/ID is flushed.
- With MISALIGN_CHECK_EN, target 0x22: misalign=1, PC is frozen, and valid=0 until reset; reset clears misalign to 0.
- Reset asserted mid-stream at PC=0x40: all outputs return to their reset values asynchronously, before the next clock edge.
